// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage valid/ready sign/exp/frac minifloat multiplier with ovf/udf flags
// Define FP_MUL_PIPE_RNE_EN for round-to-nearest-even; truncation otherwise.
module fp_mul_pipe #(
    parameter int EXP_W  = 3,
    parameter int FRAC_W = 4,
    parameter int BIAS   = 2**(EXP_W-1)-1,
    localparam int W     = 1 + EXP_W + FRAC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c,
    output logic         ovf,
    output logic         udf
);
    localparam int EW   = EXP_W + 2;
    localparam int PW   = 2*FRAC_W + 2;
`ifdef FP_MUL_PIPE_RNE_EN
    localparam int DROP = 0;
`else
    localparam int DROP = FRAC_W;   // truncation never looks below the kept fraction
`endif
    localparam int MW   = PW - DROP;
    localparam int EMAX = 2**EXP_W - 1;

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    logic          s1_valid, s1_zero, s1_spa, s1_spb, s1_sign;
    logic [EW-1:0] s1_esum;
    logic [W-1:0]  s1_a, s1_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
            s1_spa   <= 1'b0;
            s1_spb   <= 1'b0;
            s1_sign  <= 1'b0;
            s1_esum  <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            s1_zero  <= (a[W-2:0] == '0) || (b[W-2:0] == '0);
            s1_spa   <= &a[W-2 -: EXP_W];
            s1_spb   <= &b[W-2 -: EXP_W];
            s1_sign  <= a[W-1] ^ b[W-1];
            s1_esum  <= EW'(a[W-2 -: EXP_W]) + EW'(b[W-2 -: EXP_W]);
            s1_a     <= a;
            s1_b     <= b;
        end
    end

    logic [PW-1:0]        ma, mb;
    logic                 s2_valid, s2_zero, s2_spa, s2_spb, s2_sign;
    logic signed [EW-1:0] s2_exp;
    logic [MW-1:0]        s2_mant;
    logic [W-1:0]         s2_a, s2_b;

    assign ma = PW'({1'b1, s1_a[FRAC_W-1:0]});
    assign mb = PW'({1'b1, s1_b[FRAC_W-1:0]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_zero  <= 1'b0;
            s2_spa   <= 1'b0;
            s2_spb   <= 1'b0;
            s2_sign  <= 1'b0;
            s2_exp   <= '0;
            s2_mant  <= '0;
            s2_a     <= '0;
            s2_b     <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_zero  <= s1_zero;
            s2_spa   <= s1_spa;
            s2_spb   <= s1_spb;
            s2_sign  <= s1_sign;
            s2_exp   <= s1_esum - EW'(BIAS);
            s2_mant  <= MW'((ma * mb) >> DROP);
            s2_a     <= s1_a;
            s2_b     <= s1_b;
        end
    end

    logic                 msb, carry, rnd;
    logic [FRAC_W-1:0]    frac_t, frac_r;
    logic signed [EW-1:0] e_n;

    // Product lies in [1,4): msb selects the normalisation shift
    always_comb begin
        msb    = s2_mant[MW-1];
        frac_t = msb ? s2_mant[MW-2 -: FRAC_W] : s2_mant[MW-3 -: FRAC_W];
`ifdef FP_MUL_PIPE_RNE_EN
        begin
            logic guard, sticky;
            guard  = msb ? s2_mant[FRAC_W]      : s2_mant[FRAC_W-1];
            sticky = msb ? |s2_mant[FRAC_W-1:0] : |s2_mant[FRAC_W-2:0];
            rnd    = guard & (sticky | frac_t[0]);
        end
`else
        rnd    = 1'b0;
`endif
        {carry, frac_r} = {1'b0, frac_t} + (FRAC_W+1)'(rnd);
        e_n    = s2_exp + EW'(msb) + EW'(carry);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            if (s2_zero) begin
                c <= '0;
            end else if (s2_spa) begin
                c <= s2_a;
            end else if (s2_spb) begin
                c <= s2_b;
            end else if (int'(e_n) >= EMAX) begin
                c   <= {s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                ovf <= 1'b1;
            end else if (int'(e_n) <= 0) begin
                c   <= '0;
                udf <= 1'b1;
            end else begin
                c <= {s2_sign, e_n[EXP_W-1:0], frac_r};
            end
        end
    end
endmodule
